// File: rtl/operand_select_pipe.sv
// Registered operand selector with valid/ready handshake and optional auto-scan.
// Define MUX_SELERR_EN to add the sticky out-of-range flag port SelErr.
module operand_select_pipe #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [NUM_IN*WIDTH-1:0]   DataIn,
  input  logic [SEL_W-1:0]          Selector,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic                      Scan,
  output logic [WIDTH-1:0]          Output,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [SEL_W-1:0]          CurSel
`ifdef MUX_SELERR_EN
  ,
  output logic                      SelErr
`endif
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] sel_data;
  logic             in_range;
  logic             accept;

  assign InReady = !valid_q || OutReady;
  assign accept  = InValid && InReady;
  assign idx     = Scan ? scan_cnt_q : Selector;

  // Channels at or beyond NUM_IN read as zero and flag in_range low.
  always_comb begin
    sel_data = '0;
    in_range = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (idx == SEL_W'(k)) begin
        sel_data = DataIn[k*WIDTH +: WIDTH];
        in_range = 1'b1;
      end
    end
  end

  always_comb begin
    out_d      = out_q;
    cur_sel_d  = cur_sel_q;
    valid_d    = valid_q;
    scan_cnt_d = scan_cnt_q;
    if (accept) begin
      out_d     = sel_data;
      cur_sel_d = idx;
      valid_d   = 1'b1;
    end else if (OutReady) begin
      valid_d = 1'b0;
    end
    if (!Scan) begin
      scan_cnt_d = '0;
    end else if (accept) begin
      scan_cnt_d = (scan_cnt_q == SEL_W'(NUM_IN - 1)) ? '0 : scan_cnt_q + SEL_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_q      <= '0;
      cur_sel_q  <= '0;
      valid_q    <= 1'b0;
      scan_cnt_q <= '0;
    end else begin
      out_q      <= out_d;
      cur_sel_q  <= cur_sel_d;
      valid_q    <= valid_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign Output   = out_q;
  assign CurSel   = cur_sel_q;
  assign OutValid = valid_q;

`ifdef MUX_SELERR_EN
  logic sel_err_q, sel_err_d;

  always_comb begin
    sel_err_d = sel_err_q || (accept && !in_range);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign SelErr = sel_err_q;
`endif

endmodule

// File: tb/tb_operand_select_pipe.sv
// Directed bench for operand_select_pipe: a 4-channel instance plus a 3-channel
// instance for out-of-range selection (SelErr checked when MUX_SELERR_EN is defined).
module tb_operand_select_pipe;

  logic        clk = 1'b0;
  logic        reset;

  logic [63:0] data_in_a;
  logic [1:0]  selector_a;
  logic        in_valid_a, in_ready_a, scan_a;
  logic [15:0] output_a;
  logic        out_valid_a, out_ready_a;
  logic [1:0]  cur_sel_a;

  logic [47:0] data_in_b;
  logic [1:0]  selector_b;
  logic        in_valid_b, in_ready_b, scan_b;
  logic [15:0] output_b;
  logic        out_valid_b, out_ready_b;
  logic [1:0]  cur_sel_b;

`ifdef MUX_SELERR_EN
  logic        sel_err_a, sel_err_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_select_pipe #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dut_a (
    .CLK(clk), .Reset(reset), .DataIn(data_in_a), .Selector(selector_a),
    .InValid(in_valid_a), .InReady(in_ready_a), .Scan(scan_a),
    .Output(output_a), .OutValid(out_valid_a), .OutReady(out_ready_a),
    .CurSel(cur_sel_a)
`ifdef MUX_SELERR_EN
    , .SelErr(sel_err_a)
`endif
  );

  operand_select_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut_b (
    .CLK(clk), .Reset(reset), .DataIn(data_in_b), .Selector(selector_b),
    .InValid(in_valid_b), .InReady(in_ready_b), .Scan(scan_b),
    .Output(output_b), .OutValid(out_valid_b), .OutReady(out_ready_b),
    .CurSel(cur_sel_b)
`ifdef MUX_SELERR_EN
    , .SelErr(sel_err_b)
`endif
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkA(input string tag, input logic [15:0] exp_out,
                        input logic [1:0] exp_sel, input logic exp_valid);
    checkOutput({tag, " Output"}, 32'(output_a), 32'(exp_out));
    checkOutput({tag, " CurSel"}, 32'(cur_sel_a), 32'(exp_sel));
    checkOutput({tag, " OutValid"}, 32'(out_valid_a), 32'(exp_valid));
  endtask

  logic [15:0] chan [4];
  logic [1:0]  stream_sel [4];

  initial begin
    chan[0] = 16'h1111; chan[1] = 16'h2222; chan[2] = 16'h3333; chan[3] = 16'h4444;
    stream_sel[0] = 2'd0; stream_sel[1] = 2'd1; stream_sel[2] = 2'd3; stream_sel[3] = 2'd2;

    reset       = 1'b1;
    data_in_a   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    selector_a  = 2'd0; in_valid_a = 1'b0; scan_a = 1'b0; out_ready_a = 1'b0;
    data_in_b   = {16'h3333, 16'h2222, 16'h1111};
    selector_b  = 2'd0; in_valid_b = 1'b0; scan_b = 1'b0; out_ready_b = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;

    checkA("reset", 16'h0000, 2'd0, 1'b0);
    checkOutput("reset InReady", 32'(in_ready_a), 32'd1);

    // Direct mode single accept
    selector_a = 2'd2; in_valid_a = 1'b1; out_ready_a = 1'b1;
    applyStimulus();
    checkA("direct sel2", 16'h3333, 2'd2, 1'b1);

    // Backpressure: result held while selector wanders
    out_ready_a = 1'b0;
    selector_a = 2'd0;
    #1 checkOutput("bp InReady pre", 32'(in_ready_a), 32'd0);
    applyStimulus();
    checkA("bp cycle1", 16'h3333, 2'd2, 1'b1);
    checkOutput("bp InReady 1", 32'(in_ready_a), 32'd0);
    selector_a = 2'd1;
    applyStimulus();
    checkA("bp cycle2", 16'h3333, 2'd2, 1'b1);
    checkOutput("bp InReady 2", 32'(in_ready_a), 32'd0);
    selector_a = 2'd3;
    applyStimulus();
    checkA("bp cycle3", 16'h3333, 2'd2, 1'b1);
    checkOutput("bp InReady 3", 32'(in_ready_a), 32'd0);

    // Release and stream 0,1,3,2 at full throughput
    out_ready_a = 1'b1;
    #1 checkOutput("release InReady", 32'(in_ready_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      selector_a = stream_sel[i];
      applyStimulus();
      checkA($sformatf("stream %0d", i), chan[stream_sel[i]], stream_sel[i], 1'b1);
    end

    // Drain, then selector change while idle has no effect
    in_valid_a = 1'b0;
    applyStimulus();
    checkA("drain", 16'h3333, 2'd2, 1'b0);
    selector_a = 2'd1;
    applyStimulus();
    checkA("idle sel change", 16'h3333, 2'd2, 1'b0);

    // Auto-scan for 6 cycles: 0,1,2,3,0,1
    scan_a = 1'b1; in_valid_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkA($sformatf("scan %0d", i), chan[i % 4], 2'(i % 4), 1'b1);
    end

    // Leaving scan mode restarts the counter at channel 0
    scan_a = 1'b0; selector_a = 2'd3;
    applyStimulus();
    checkA("direct after scan", 16'h4444, 2'd3, 1'b1);
    scan_a = 1'b1;
    applyStimulus();
    checkA("scan restart", 16'h1111, 2'd0, 1'b1);
    scan_a = 1'b0;

    // Reset while a result is stalled
    out_ready_a = 1'b0; selector_a = 2'd1;
    applyStimulus();
    checkA("stall before reset", 16'h1111, 2'd0, 1'b1);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkA("reset during stall", 16'h0000, 2'd0, 1'b0);
    checkOutput("reset stall InReady", 32'(in_ready_a), 32'd1);
    in_valid_a = 1'b0;

    // Three-channel instance: out-of-range selector
    selector_b = 2'd1; in_valid_b = 1'b1;
    applyStimulus();
    checkOutput("b in-range Output", 32'(output_b), 32'h2222);
    selector_b = 2'd3;
    applyStimulus();
    checkOutput("b oor Output", 32'(output_b), 32'h0000);
    checkOutput("b oor CurSel", 32'(cur_sel_b), 32'd3);
    checkOutput("b oor OutValid", 32'(out_valid_b), 32'd1);
`ifdef MUX_SELERR_EN
    checkOutput("b SelErr set", 32'(sel_err_b), 32'd1);
    checkOutput("a SelErr clear", 32'(sel_err_a), 32'd0);
`endif
    selector_b = 2'd2;
    applyStimulus();
    checkOutput("b after oor Output", 32'(output_b), 32'h3333);
    checkOutput("b after oor CurSel", 32'(cur_sel_b), 32'd2);
`ifdef MUX_SELERR_EN
    checkOutput("b SelErr sticky", 32'(sel_err_b), 32'd1);
`endif
    in_valid_b = 1'b0;
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("b reset Output", 32'(output_b), 32'h0000);
    checkOutput("b reset OutValid", 32'(out_valid_b), 32'd0);
`ifdef MUX_SELERR_EN
    checkOutput("b SelErr reset", 32'(sel_err_b), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
